// File: rtl/cpu_pkg.sv
// Datapath constants and types shared across the 16-bit CPU.
// Register-file width, depth and address typedefs live here.
package cpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/register_file.sv
// General-purpose register file: 16 x 16-bit, one synchronous write port and
// two independent combinational read ports with no write-through bypass.
module register_file
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] reg_write_dest,
  input  logic [DATA_WIDTH-1:0] reg_write_data,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
  output logic [DATA_WIDTH-1:0] reg_read_data_1,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
  output logic [DATA_WIDTH-1:0] reg_read_data_2
);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (reg_write_en) begin
      regs_d[reg_write_dest] = reg_write_data;
    end
  end

  // Reset wins over a same-edge write, so the write computed in regs_d is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign reg_read_data_1 = regs_q[reg_read_addr_1];
  assign reg_read_data_2 = regs_q[reg_read_addr_2];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: expected read data is queued when the
// read addresses are driven and popped when the combinational outputs settle.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        reg_write_en;
  logic [3:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [3:0]  reg_read_addr_1;
  logic [15:0] reg_read_data_1;
  logic [3:0]  reg_read_addr_2;
  logic [15:0] reg_read_data_2;

  typedef struct {
    string       tag;
    logic [15:0] exp_1;
    logic [15:0] exp_2;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model [16];
  int          checks;
  int          errors;

  register_file dut (
    .clk             (clk),
    .rst             (rst),
    .reg_write_en    (reg_write_en),
    .reg_write_dest  (reg_write_dest),
    .reg_write_data  (reg_write_data),
    .reg_read_addr_1 (reg_read_addr_1),
    .reg_read_data_1 (reg_read_data_1),
    .reg_read_addr_2 (reg_read_addr_2),
    .reg_read_data_2 (reg_read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic we,
                               input logic [3:0] dest, input logic [15:0] data);
    rst            = rst_v;
    reg_write_en   = we;
    reg_write_dest = dest;
    reg_write_data = data;
  endtask

  // One rising edge; the reference model follows the same reset/write rules.
  task automatic clockEdge();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    end else if (reg_write_en) begin
      model[reg_write_dest] = reg_write_data;
    end
    #1;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] a1, input logic [3:0] a2,
                           input logic [15:0] e1, input logic [15:0] e2);
    exp_t item;
    reg_read_addr_1 = a1;
    reg_read_addr_2 = a2;
    item.tag   = tag;
    item.exp_1 = e1;
    item.exp_2 = e2;
    exp_q.push_back(item);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty", tag);
    end else begin
      item = exp_q.pop_front();
      checkOutput({item.tag, "_p1"}, reg_read_data_1, item.exp_1);
      checkOutput({item.tag, "_p2"}, reg_read_data_2, item.exp_2);
    end
  endtask

  initial begin
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [3:0]  dest;
    logic [15:0] data;
    checks = 0;
    errors = 0;
    reg_read_addr_1 = 4'd0;
    reg_read_addr_2 = 4'd0;
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000);
    readCheck("por_reset", 4'd0, 4'd15, 16'h0000, 16'h0000);

    // Test 1: fill with distinct values, then one reset edge clears everything
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 4'(i), 16'h5A00 + 16'(i));
      clockEdge();
    end
    readCheck("prefill", 4'd6, 4'd11, 16'h5A06, 16'h5A0B);
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      readCheck("reset_clear", 4'(i), 4'(15 - i), 16'h0000, 16'h0000);
    end

    // Test 2: write sweep, then read every address without a clock edge
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 4'(i), 16'h1000 + 16'(i));
      clockEdge();
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      readCheck("sweep", 4'(i), 4'(i), 16'h1000 + 16'(i), 16'h1000 + 16'(i));
    end

    // Test 3: dual-port
    readCheck("dual_diff", 4'd3, 4'd12, 16'h1003, 16'h100C);
    readCheck("dual_same", 4'd5, 4'd5, 16'h1005, 16'h1005);

    // Test 4: write enable low
    applyStimulus(1'b0, 1'b0, 4'd7, 16'hBEEF);
    clockEdge();
    readCheck("we_low", 4'd7, 4'd0, 16'h1007, 16'h1000);

    // Test 5: read during write returns old data until the edge
    applyStimulus(1'b0, 1'b1, 4'd9, 16'hA5A5);
    readCheck("rdw_before", 4'd9, 4'd9, 16'h1009, 16'h1009);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000);
    readCheck("rdw_after", 4'd9, 4'd8, 16'hA5A5, 16'h1008);

    // Random traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      dest = 4'($urandom_range(0, 15));
      data = 16'($urandom);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), dest, data);
      clockEdge();
      a1 = 4'($urandom_range(0, 15));
      a2 = dest;
      readCheck("random", a1, a2, model[a1], model[a2]);
    end

    // Test 6: reset beats a simultaneous write; outputs fall to 0
    applyStimulus(1'b0, 1'b1, 4'd4, 16'h4444);
    clockEdge();
    readCheck("pre_rst_wr", 4'd4, 4'd9, model[4], model[9]);
    applyStimulus(1'b1, 1'b1, 4'd4, 16'hFFFF);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000);
    readCheck("rst_vs_wr", 4'd4, 4'd9, 16'h0000, 16'h0000);
    readCheck("rst_vs_wr_r0", 4'd0, 4'd15, 16'h0000, 16'h0000);

    // Register 0 is an ordinary writable register
    applyStimulus(1'b0, 1'b1, 4'd0, 16'hC0DE);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000);
    readCheck("reg0_write", 4'd0, 4'd1, 16'hC0DE, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
